delay_sweep_controller: RTL
===========================

Name: delay_sweep_controller

Overview:
- Sequencer for `programmable_delay`, used when the delay line is closed into a ring oscillator.
- Steps the delay code from CODE_FIRST to CODE_LAST and waits a settle time after each code change.
- Measures the ring frequency by counting oscillator rising edges over a fixed gate window of system clocks.
- Reports one (code, count) result per step over a valid/ready handshake; on the board it sits between the switches/logger and the delay line.

Parameters:
- N, 18, delay code width (matches the delay line).
- SETTLE_CYCLES, 64, clocks held after each code change before counting starts (≥1).
- GATE_CYCLES, 50000, length of the counting window in clocks (≥2).
- CW, 20, edge count width; the count saturates at 2^CW-1.

Ports:
- CLOCK_50  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  sweep request, sampled in IDLE only.
- MANUAL_EN  in  1  in IDLE, CODE follows MANUAL_CODE.
- MANUAL_CODE  in  N  manual delay code.
- CODE_FIRST  in  N  first sweep code.
- CODE_LAST  in  N  last sweep code (inclusive).
- RING_IN  in  1  ring oscillator output, asynchronous to CLOCK_50.
- CODE  out  N  registered code to the delay line.
- RESULT_CODE  out  N  code of the current result.
- RESULT_COUNT  out  CW  edges counted in the gate window.
- RESULT_VALID  out  1  result available.
- RESULT_READY  in  1  consumer accepts the result.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse after the final result is accepted.

Behaviour:
- Reset (RST_N low at a clock edge):
  - state ← IDLE; CODE, RESULT_CODE, RESULT_COUNT ← 0; RESULT_VALID, BUSY, DONE ← 0.
  - Synchronizer and counters are cleared.
  - Reset mid-sweep abandons the sweep; no partial result is emitted.
- IDLE:
  - CODE ← MANUAL_EN ? MANUAL_CODE : hold, updated every clock.
  - START=1 → latch CODE_FIRST/CODE_LAST; CODE ← CODE_FIRST on the next edge; enter SETTLE.
  - dir ← up if CODE_LAST ≥ CODE_FIRST, else down.
  - CODE_FIRST == CODE_LAST gives a one-point sweep.
- SETTLE: count SETTLE_CYCLES clocks with CODE stable, then enter MEASURE.
- MEASURE:
  - Window is exactly GATE_CYCLES clocks.
  - Edge count increments on each synchronized rising edge (2-flop synchronizer plus edge-detect flop) detected inside the window.
  - Edge count saturates at 2^CW-1 and never wraps.
  - The edge count resets to 0 on entry to MEASURE.
  - Accuracy requires a ring period greater than 2 clocks; faster rings alias (documented limitation, no detection).
- REPORT:
  - The clock after the window ends: RESULT_VALID=1, RESULT_CODE=CODE, RESULT_COUNT=count.
  - Outputs hold stable until RESULT_VALID && RESULT_READY at a clock edge; READY may be held high.
  - On accept: RESULT_VALID ← 0.
  - If CODE == latched CODE_LAST → IDLE with DONE=1 for one cycle.
  - Otherwise CODE ← CODE ± 1 per dir, then SETTLE.
  - Termination is on equality, so the code never wraps, including at 0 and 2^N-1.
- START while BUSY is ignored.
- MANUAL_EN and the CODE_* inputs are ignored while BUSY (they were latched at start).
- Latency per step: 1 + SETTLE_CYCLES + GATE_CYCLES + 1 clocks, plus any back-pressure stall.

Decomposition:
- Shared package:
  - State enum {IDLE, SETTLE, MEASURE, REPORT}.
  - Default widths N, CW, shared with `programmable_delay`.
- One sub-module, `ring_edge_counter`:
  - Synchronizer, rising-edge detect, saturating counter.
  - Inputs: clear and enable.
- The FSM and the settle/gate timers stay in the top.

Test Plan:
Bench params N=4, SETTLE_CYCLES=4, GATE_CYCLES=16, CW=4; RING_IN driven with period 4×CLOCK_50 unless noted.
1. Reset: hold RST_N=0 for 3 clocks during MEASURE → next cycle all outputs 0, state IDLE, no RESULT_VALID.
2. Up sweep: FIRST=2, LAST=5, READY=1 → 4 results with RESULT_CODE 2,3,4,5, each RESULT_COUNT=4; results spaced 22 clocks apart; DONE pulse after code 5; BUSY low afterwards.
3. Down sweep with back-pressure: FIRST=9, LAST=7, READY low for 10 clocks on each result → codes 9,8,7; RESULT_* held stable while stalled; CODE unchanged until accept.
4. Saturation: RING_IN period 2 clocks with CW=3 → RESULT_COUNT=7, not wrapped.
5. Edges of range: FIRST=LAST=15 → exactly one result, no wrap to 0. Then FIRST=0, LAST=0 with RING_IN held low → RESULT_COUNT=0.
6. Manual mode and ignored START: MANUAL_EN=1, MANUAL_CODE=11 in IDLE → CODE=11 on the next clock. A second START pulse mid-sweep → no restart; sequence identical to test 2.

Source files
------------

// File: rtl/delay_sweep_controller_pkg.sv
// Shared types and default widths for the delay sweep controller.
// Widths match the programmable_delay line it drives.
package delay_sweep_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } state_t;

    localparam int N_DEFAULT  = 18;
    localparam int CW_DEFAULT = 20;

endpackage

// File: rtl/ring_edge_counter.sv
// Counts rising edges of an asynchronous ring oscillator output.
// Two-flop synchronizer, edge-detect flop, saturating counter.
module ring_edge_counter #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ring,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    logic [2:0] sync;
    logic       rise;

    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            count <= '0;
        end else begin
            sync <= {sync[1:0], ring};
            if (clear) begin
                count <= '0;
            end else if (enable && rise && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_sweep_controller.sv
// Steps the delay code across a range, settles, counts ring edges over a
// fixed gate window and hands out one (code, count) result per step.
module delay_sweep_controller
    import delay_sweep_controller_pkg::*;
#(
    parameter int N             = N_DEFAULT,
    parameter int SETTLE_CYCLES = 64,
    parameter int GATE_CYCLES   = 50000,
    parameter int CW            = CW_DEFAULT
) (
    input  logic          CLOCK_50,
    input  logic          RST_N,
    input  logic          START,
    input  logic          MANUAL_EN,
    input  logic [N-1:0]  MANUAL_CODE,
    input  logic [N-1:0]  CODE_FIRST,
    input  logic [N-1:0]  CODE_LAST,
    input  logic          RING_IN,
    output logic [N-1:0]  CODE,
    output logic [N-1:0]  RESULT_CODE,
    output logic [CW-1:0] RESULT_COUNT,
    output logic          RESULT_VALID,
    input  logic          RESULT_READY,
    output logic          BUSY,
    output logic          DONE
);

    localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES) ?
                          SETTLE_CYCLES : GATE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] GATE_END   = TW'(GATE_CYCLES - 1);

    state_t        state, state_n;
    logic [N-1:0]  code, code_n;
    logic [N-1:0]  last, last_n;
    logic          up, up_n;
    logic [TW-1:0] timer, timer_n;
    logic [N-1:0]  rcode, rcode_n;
    logic          rvalid, rvalid_n;
    logic          done, done_n;
    logic          clear;
    logic          enable;
    logic [CW-1:0] count;

    ring_edge_counter #(.CW(CW)) u_counter (
        .clk    (CLOCK_50),
        .rst_n  (RST_N),
        .ring   (RING_IN),
        .clear  (clear),
        .enable (enable),
        .count  (count)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state  <= IDLE;
            code   <= '0;
            last   <= '0;
            up     <= 1'b1;
            timer  <= '0;
            rcode  <= '0;
            rvalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            code   <= code_n;
            last   <= last_n;
            up     <= up_n;
            timer  <= timer_n;
            rcode  <= rcode_n;
            rvalid <= rvalid_n;
            done   <= done_n;
        end
    end

    // SETTLE spans the code-change clock plus SETTLE_CYCLES stable clocks.
    always_comb begin
        state_n  = state;
        code_n   = code;
        last_n   = last;
        up_n     = up;
        timer_n  = timer;
        rcode_n  = rcode;
        rvalid_n = rvalid;
        done_n   = 1'b0;
        clear    = 1'b0;
        enable   = (state == MEASURE);
        unique case (state)
            IDLE: begin
                if (MANUAL_EN) begin
                    code_n = MANUAL_CODE;
                end
                if (START) begin
                    state_n = SETTLE;
                    code_n  = CODE_FIRST;
                    last_n  = CODE_LAST;
                    up_n    = (CODE_LAST >= CODE_FIRST);
                    timer_n = '0;
                end
            end
            SETTLE: begin
                if (timer == SETTLE_END) begin
                    state_n = MEASURE;
                    timer_n = '0;
                    clear   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            MEASURE: begin
                if (timer == GATE_END) begin
                    state_n  = REPORT;
                    rvalid_n = 1'b1;
                    rcode_n  = code;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            REPORT: begin
                if (rvalid && RESULT_READY) begin
                    rvalid_n = 1'b0;
                    timer_n  = '0;
                    if (code == last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SETTLE;
                        code_n  = up ? code + 1'b1 : code - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign CODE         = code;
    assign RESULT_CODE  = rcode;
    assign RESULT_COUNT = count;
    assign RESULT_VALID = rvalid;
    assign BUSY         = (state != IDLE);
    assign DONE         = done;

endmodule
